// File: rtl/data_memory.sv
// rtl/data_memory.sv - Word-addressed data RAM with a bring-up MMIO register window
module data_memory #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        DMEM_write_i,
    input  logic        DMEM_read_i,
    input  logic [31:0] DMEM_addr_i,
    input  logic [31:0] DMEM_data_i,
    output logic [31:0] DMEM_data_o,
    output logic [31:0] tohost_o,
    output logic        tohost_valid_o,
    output logic        halt_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [3:0] OFF_TOHOST = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h4;
    localparam logic [3:0] OFF_STORES = 4'h8;
    localparam logic [3:0] OFF_HALT   = 4'hC;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   cycle_count;
    logic [31:0]   store_count;

    logic          is_mmio;
    logic [AW-1:0] ram_idx;
    logic [3:0]    mmio_off;
    logic          commit;
    logic          ram_we;
    logic          mmio_we;
    logic          unused_addr_bits;

    // Only bit 31 distinguishes the register window; the rest of the base is informational.
    assign is_mmio  = (DMEM_addr_i[31] == MMIO_BASE[31]);
    assign ram_idx  = DMEM_addr_i[AW+1:2];
    assign mmio_off = DMEM_addr_i[3:0];

    // Stores are dropped during reset and after halt.
    assign commit  = DMEM_write_i && reset_n && !halt_o;
    assign ram_we  = commit && !is_mmio;
    assign mmio_we = commit && is_mmio;

    // Address bits above the RAM index alias; byte offset is ignored.
    assign unused_addr_bits = ^{DMEM_addr_i[30:AW+2], DMEM_addr_i[1:0]};

    // RAM array: synchronous write, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= DMEM_data_i;
        end
    end

    // Register window state: counters, mailbox, valid pulse and sticky halt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tohost_o       <= 32'h0;
            tohost_valid_o <= 1'b0;
            halt_o         <= 1'b0;
            cycle_count    <= 32'h0;
            store_count    <= 32'h0;
        end else begin
            tohost_valid_o <= 1'b0;
            if (!halt_o) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (ram_we) begin
                store_count <= store_count + 32'd1;
            end
            if (mmio_we) begin
                case (mmio_off)
                    OFF_TOHOST: begin
                        tohost_o       <= DMEM_data_i;
                        tohost_valid_o <= 1'b1;
                    end
                    OFF_HALT: halt_o <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    // Zero-latency read mux; returns pre-edge contents and zero when no load is requested.
    always_comb begin
        DMEM_data_o = 32'h0;
        if (DMEM_read_i) begin
            if (is_mmio) begin
                case (mmio_off)
                    OFF_TOHOST: DMEM_data_o = tohost_o;
                    OFF_CYCLE:  DMEM_data_o = cycle_count;
                    OFF_STORES: DMEM_data_o = store_count;
                    OFF_HALT:   DMEM_data_o = {31'b0, halt_o};
                    default:    DMEM_data_o = 32'h0;
                endcase
            end else begin
                DMEM_data_o = mem[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - Directed vector testbench for data_memory
module tb_data_memory;

    logic        clk;
    logic        reset_n;
    logic        DMEM_write_i;
    logic        DMEM_read_i;
    logic [31:0] DMEM_addr_i;
    logic [31:0] DMEM_data_i;
    logic [31:0] DMEM_data_o;
    logic [31:0] tohost_o;
    logic        tohost_valid_o;
    logic        halt_o;

    int checks;
    int errors;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    vec_t vecs[$];

    data_memory #(
        .DEPTH_WORDS(1024),
        .MMIO_BASE  (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .DMEM_write_i  (DMEM_write_i),
        .DMEM_read_i   (DMEM_read_i),
        .DMEM_addr_i   (DMEM_addr_i),
        .DMEM_data_i   (DMEM_data_i),
        .DMEM_data_o   (DMEM_data_o),
        .tohost_o      (tohost_o),
        .tohost_valid_o(tohost_valid_o),
        .halt_o        (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wdata);
        DMEM_write_i = wr;
        DMEM_read_i  = rd;
        DMEM_addr_i  = addr;
        DMEM_data_i  = wdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        apply(1'b0, 1'b0, 32'h0, 32'h0);

        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, "idle1"});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, "idle2"});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, "idle3"});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, "idle4"});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, "idle5"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_0004, 32'h0, 32'd5, "cycle_after_5"});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "wr_10"});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "rd_10"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_0008, 32'h0, 32'd1, "stores_1"});
        vecs.push_back('{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, "rw_same_old"});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h1234_5678, "rw_same_new"});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0, "wr_alias"});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'hA5A5_A5A5, "rd_alias"});
        vecs.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, "rd_disabled"});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_1002, 32'h0, 32'hA5A5_A5A5, "rd_byte_ofs"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_0008, 32'h0, 32'd3, "stores_3"});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0004, 32'h55, 32'h0, "wr_cycle_ro"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_0004, 32'h0, 32'd17, "cycle_17"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_0008, 32'h0, 32'd3, "stores_mmio_wr"});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0008, 32'h99, 32'h0, "wr_stores_ro"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_0008, 32'h0, 32'd3, "stores_ro_kept"});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0, 32'd21, "cycle_mmio_alias"});
        vecs.push_back('{1'b0, 1'b1, 32'h8000_000C, 32'h0, 32'd0, "halt_rd_0"});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h1111_1111, 32'h0, "wr_20"});

        // Reset state, store during reset is dropped and read path stays live.
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply(1'b1, 1'b1, 32'h8000_0004, 32'h0000_0BAD);
        #1;
        check("rst_tohost", tohost_o, 32'h0);
        check("rst_valid", {31'b0, tohost_valid_o}, 32'h0);
        check("rst_halt", {31'b0, halt_o}, 32'h0);
        check("rst_cycle", DMEM_data_o, 32'h0);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h8000_0008, 32'h0);
        #1;
        check("rst_stores", DMEM_data_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            #1;
            check(vecs[i].name, DMEM_data_o, vecs[i].exp_rdata);
            @(negedge clk);
        end

        // TOHOST single pulse.
        apply(1'b1, 1'b0, 32'h8000_0000, 32'h1);
        #1;
        check("th_pre_valid", {31'b0, tohost_valid_o}, 32'h0);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h8000_0000, 32'h0);
        #1;
        check("th_val", tohost_o, 32'h1);
        check("th_valid_hi", {31'b0, tohost_valid_o}, 32'h1);
        check("th_rd", DMEM_data_o, 32'h1);
        @(negedge clk);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("th_valid_lo", {31'b0, tohost_valid_o}, 32'h0);
        check("th_held", tohost_o, 32'h1);
        @(negedge clk);

        // TOHOST back-to-back writes.
        apply(1'b1, 1'b0, 32'h8000_0000, 32'h2);
        @(negedge clk);
        apply(1'b1, 1'b0, 32'h8000_0000, 32'h3);
        #1;
        check("th_b2b_v1", {31'b0, tohost_valid_o}, 32'h1);
        check("th_b2b_d1", tohost_o, 32'h2);
        @(negedge clk);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("th_b2b_v2", {31'b0, tohost_valid_o}, 32'h1);
        check("th_b2b_d2", tohost_o, 32'h3);
        @(negedge clk);
        #1;
        check("th_b2b_end", {31'b0, tohost_valid_o}, 32'h0);

        // CYCLE wraparound.
        apply(1'b0, 1'b1, 32'h8000_0004, 32'h0);
        force dut.cycle_count = 32'hFFFF_FFFF;
        #1;
        check("cyc_preset", DMEM_data_o, 32'hFFFF_FFFF);
        release dut.cycle_count;
        @(negedge clk);
        #1;
        check("cyc_wrap", DMEM_data_o, 32'h0);

        // HALT: the halting edge still counts, then everything freezes.
        apply(1'b1, 1'b0, 32'h8000_000C, 32'h0);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h8000_0004, 32'h0);
        #1;
        check("halt_set", {31'b0, halt_o}, 32'h1);
        check("halt_cyc", DMEM_data_o, 32'd1);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h8000_000C, 32'h0);
        #1;
        check("halt_rd_1", DMEM_data_o, 32'h1);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 1'b1, 32'h0000_0020, 32'h77);
            #1;
            check($sformatf("halt_wr_blk%0d", k), DMEM_data_o, 32'h1111_1111);
            @(negedge clk);
        end
        apply(1'b1, 1'b1, 32'h8000_0004, 32'h99);
        #1;
        check("halt_cyc_frz", DMEM_data_o, 32'd1);
        @(negedge clk);
        apply(1'b1, 1'b1, 32'h8000_0000, 32'h99);
        #1;
        check("halt_stores", tohost_o, 32'h3);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h8000_0008, 32'h0);
        #1;
        check("halt_th_blk", tohost_o, 32'h3);
        check("halt_th_nov", {31'b0, tohost_valid_o}, 32'h0);
        check("halt_st_cnt", DMEM_data_o, 32'd4);
        @(negedge clk);

        // Reset clears halt, drops the concurrent store, keeps RAM.
        reset_n = 1'b0;
        apply(1'b1, 1'b1, 32'h0000_0010, 32'h0000_BAD0);
        #1;
        check("rst2_rd_live", DMEM_data_o, 32'h1234_5678);
        @(negedge clk);
        reset_n = 1'b1;
        apply(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        #1;
        check("rst2_halt", {31'b0, halt_o}, 32'h0);
        check("rst2_tohost", tohost_o, 32'h0);
        check("rst2_ram", DMEM_data_o, 32'h1234_5678);
        @(negedge clk);
        apply(1'b1, 1'b1, 32'h8000_0008, 32'h0);
        #1;
        check("rst2_stores", DMEM_data_o, 32'h0);
        apply(1'b1, 1'b0, 32'h0000_0020, 32'h77);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h0000_0020, 32'h0);
        #1;
        check("rst2_wr_ok", DMEM_data_o, 32'h77);
        @(negedge clk);
        apply(1'b0, 1'b1, 32'h8000_0008, 32'h0);
        #1;
        check("rst2_stores1", DMEM_data_o, 32'd1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
